// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the SRAM-to-SRAM-like bus bridge.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package sram_like_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] off;
  } size_off_t;

  // Byte-enable mask to bus transfer size and low address bits.
  // Masks that are not a naturally aligned byte/half/word fall back to a word.
  function automatic size_off_t wen_to_size_off(input logic [3:0] wen);
    size_off_t r;
    r.size = SZ_WORD;
    r.off  = 2'd0;
    case (wen)
      4'b0001: begin r.size = SZ_BYTE; r.off = 2'd0; end
      4'b0010: begin r.size = SZ_BYTE; r.off = 2'd1; end
      4'b0100: begin r.size = SZ_BYTE; r.off = 2'd2; end
      4'b1000: begin r.size = SZ_BYTE; r.off = 2'd3; end
      4'b0011: begin r.size = SZ_HALF; r.off = 2'd0; end
      4'b1100: begin r.size = SZ_HALF; r.off = 2'd2; end
      default: begin r.size = SZ_WORD; r.off = 2'd0; end
    endcase
    return r;
  endfunction

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto the low 512 MiB.
  function automatic logic [31:0] kseg_map(input logic [31:0] a);
    if (a[31:30] == 2'b10) begin
      return {3'b000, a[28:0]};
    end
    return a;
  endfunction

endpackage

// File: rtl/sram_like_chan.sv
// One bridge channel: IDLE/ADDR/DATA/HOLD FSM with request and response registers.
// Latency: request on the bus one cycle after cpu_en; read data in HOLD one cycle after data_ok.
// Backpressure: bus outputs frozen while addr_ok is low; HOLD persists until global stall drops.
module sram_like_chan
  import sram_like_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAP_KSEG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  input  logic              stall,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] ADDR = ST_ADDR;
  localparam logic [1:0] DATA = ST_DATA;
  localparam logic [1:0] HOLD = ST_HOLD;

  logic [1:0]        state;
  logic [ADDR_W-1:0] phys;
  logic              is_wr;
  size_off_t         so;
  logic              start;

  generate
    if (MAP_KSEG != 0) begin : g_kseg
      assign phys = ADDR_W'(kseg_map(32'(cpu_addr)));
    end else begin : g_pass
      assign phys = cpu_addr;
    end
  endgenerate

  assign is_wr = |cpu_wen;
  assign so    = wen_to_size_off(cpu_wen);
  assign start = (state == IDLE) && cpu_en;

  // A channel holds the pipeline while it has an unserved or in-flight access.
  assign busy    = start || (state == ADDR) || (state == DATA);
  assign bus_req = (state == ADDR);

  // Channel FSM; data_ok only matters in DATA, addr_ok only in ADDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (cpu_en)      state <= ADDR;
        ADDR:    if (bus_addr_ok) state <= DATA;
        DATA:    if (bus_data_ok) state <= HOLD;
        HOLD:    if (!stall)      state <= IDLE;
        default:                  state <= IDLE;
      endcase
    end
  end

  // Request registers, loaded once on acceptance so the bus sees a stable request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wdata <= 32'd0;
    end else if (start) begin
      bus_wr    <= is_wr;
      bus_size  <= is_wr ? so.size : cpu_size;
      bus_addr  <= is_wr ? {phys[ADDR_W-1:2], so.off} : phys;
      bus_wdata <= cpu_wdata;
    end
  end

  // Response register; stays put through HOLD until the global release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata <= 32'd0;
    end else if ((state == DATA) && bus_data_ok) begin
      cpu_rdata <= bus_rdata;
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// NCH-channel bridge from single-cycle SRAM ports to a req/addr_ok/data_ok bus.
// Latency: minimum 3 stalled cycles per access, released in the fourth.
// Backpressure: one global stall held until every active channel reaches HOLD.
module sram_like_bridge
  import sram_like_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int ADDR_W   = 32,
  parameter int MAP_KSEG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        cpu_en,
  input  logic [4*NCH-1:0]      cpu_wen,
  input  logic [2*NCH-1:0]      cpu_size,
  input  logic [ADDR_W*NCH-1:0] cpu_addr,
  input  logic [32*NCH-1:0]     cpu_wdata,
  output logic [32*NCH-1:0]     cpu_rdata,
  output logic                  stall,
  output logic [NCH-1:0]        bus_req,
  output logic [NCH-1:0]        bus_wr,
  output logic [2*NCH-1:0]      bus_size,
  output logic [ADDR_W*NCH-1:0] bus_addr,
  output logic [32*NCH-1:0]     bus_wdata,
  input  logic [NCH-1:0]        bus_addr_ok,
  input  logic [NCH-1:0]        bus_data_ok,
  input  logic [32*NCH-1:0]     bus_rdata
);

  logic [NCH-1:0] busy;

  assign stall = |busy;

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      sram_like_chan #(
        .ADDR_W   (ADDR_W),
        .MAP_KSEG (MAP_KSEG)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .cpu_en      (cpu_en[c]),
        .cpu_wen     (cpu_wen[4*c +: 4]),
        .cpu_size    (cpu_size[2*c +: 2]),
        .cpu_addr    (cpu_addr[ADDR_W*c +: ADDR_W]),
        .cpu_wdata   (cpu_wdata[32*c +: 32]),
        .cpu_rdata   (cpu_rdata[32*c +: 32]),
        .stall       (stall),
        .busy        (busy[c]),
        .bus_req     (bus_req[c]),
        .bus_wr      (bus_wr[c]),
        .bus_size    (bus_size[2*c +: 2]),
        .bus_addr    (bus_addr[ADDR_W*c +: ADDR_W]),
        .bus_wdata   (bus_wdata[32*c +: 32]),
        .bus_addr_ok (bus_addr_ok[c]),
        .bus_data_ok (bus_data_ok[c]),
        .bus_rdata   (bus_rdata[32*c +: 32])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: two-channel mapped instance plus a one-channel pass-through instance.
// Latency: checks the 3-cycle minimum access and skewed channel completion.
// Backpressure: checks request stability while addr_ok is withheld.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  cpu_en = '0;
  logic [7:0]  cpu_wen = '0;
  logic [3:0]  cpu_size = '0;
  logic [63:0] cpu_addr = '0;
  logic [63:0] cpu_wdata = '0;
  logic [63:0] cpu_rdata;
  logic        stall;
  logic [1:0]  bus_req, bus_wr;
  logic [3:0]  bus_size;
  logic [63:0] bus_addr, bus_wdata;
  logic [1:0]  bus_addr_ok = '0;
  logic [1:0]  bus_data_ok = '0;
  logic [63:0] bus_rdata = '0;

  logic        m_en = 1'b0;
  logic [3:0]  m_wen = '0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata;
  logic        m_stall;
  logic        m_bus_req, m_bus_wr;
  logic [1:0]  m_bus_size;
  logic [31:0] m_bus_addr, m_bus_wdata;
  logic        m_addr_ok = 1'b0;
  logic        m_data_ok = 1'b0;
  logic [31:0] m_bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_like_bridge #(.NCH(2), .ADDR_W(32), .MAP_KSEG(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .stall(stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  sram_like_bridge #(.NCH(1), .ADDR_W(32), .MAP_KSEG(0)) dut_pass (
    .clk(clk), .rst(rst),
    .cpu_en(m_en), .cpu_wen(m_wen), .cpu_size(m_size),
    .cpu_addr(m_addr), .cpu_wdata(m_wdata), .cpu_rdata(m_rdata),
    .stall(m_stall),
    .bus_req(m_bus_req), .bus_wr(m_bus_wr), .bus_size(m_bus_size),
    .bus_addr(m_bus_addr), .bus_wdata(m_bus_wdata),
    .bus_addr_ok(m_addr_ok), .bus_data_ok(m_data_ok), .bus_rdata(m_bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write on channel 1 with minimum-latency handshakes.
  task automatic do_wr1(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] esz, input logic [31:0] ea);
    cpu_en[1]         = 1'b1;
    cpu_wen[7:4]      = wen;
    cpu_size[3:2]     = 2'd3;
    cpu_addr[63:32]   = a;
    cpu_wdata[63:32]  = d;
    #1 chk("wr_stall_c0", stall, 1);
    step();
    #1;
    chk("wr_req", bus_req[1], 1);
    chk("wr_wr", bus_wr[1], 1);
    chk("wr_size", bus_size[3:2], esz);
    chk("wr_addr", bus_addr[63:32], ea);
    chk("wr_wdata", bus_wdata[63:32], d);
    bus_addr_ok[1] = 1'b1;
    step();
    bus_addr_ok[1] = 1'b0;
    bus_data_ok[1] = 1'b1;
    #1 chk("wr_stall_c2", stall, 1);
    step();
    bus_data_ok[1] = 1'b0;
    #1 chk("wr_stall_c3", stall, 0);
    step();
    cpu_en[1]    = 1'b0;
    cpu_wen[7:4] = 4'd0;
    #1 chk("wr_idle_req", bus_req[1], 0);
  endtask

  initial begin
    // ---- reset state ----
    #12;
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_wr", 32'(bus_wr), 0);
    chk("rst_size", 32'(bus_size), 0);
    chk("rst_addr0", bus_addr[31:0], 0);
    chk("rst_addr1", bus_addr[63:32], 0);
    chk("rst_wdata0", bus_wdata[31:0], 0);
    chk("rst_rdata0", cpu_rdata[31:0], 0);
    chk("rst_rdata1", cpu_rdata[63:32], 0);
    chk("rst_stall_noen", stall, 0);
    cpu_en = 2'b01;
    #1 chk("rst_stall_en", stall, 1);
    cpu_en = 2'b00;
    step();
    rst = 1'b0;

    // ---- single read, ch0, kseg1 address ----
    cpu_en[0] = 1'b1; cpu_size[1:0] = 2'd2; cpu_addr[31:0] = 32'hBFC0_0000;
    #1;
    chk("rd_c0_stall", stall, 1);
    chk("rd_c0_req", bus_req[0], 0);
    step();
    #1;
    chk("rd_c1_req", bus_req[0], 1);
    chk("rd_c1_addr", bus_addr[31:0], 32'h1FC0_0000);
    chk("rd_c1_size", bus_size[1:0], 2);
    chk("rd_c1_wr", bus_wr[0], 0);
    chk("rd_c1_stall", stall, 1);
    bus_addr_ok[0] = 1'b1;
    step();
    bus_addr_ok[0] = 1'b0; bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'h2408_0001;
    #1;
    chk("rd_c2_stall", stall, 1);
    chk("rd_c2_req", bus_req[0], 0);
    step();
    bus_data_ok[0] = 1'b0; bus_rdata[31:0] = 32'h0;
    #1;
    chk("rd_c3_stall", stall, 0);
    chk("rd_c3_rdata", cpu_rdata[31:0], 32'h2408_0001);
    step();
    cpu_en[0] = 1'b0;
    bus_data_ok[0] = 1'b1;  // stray response in IDLE
    #1 chk("rd_c4_stall", stall, 0);
    step();
    bus_data_ok[0] = 1'b0;
    #1;
    chk("idle_stray_req", bus_req[0], 0);
    chk("idle_stray_rdata", cpu_rdata[31:0], 32'h2408_0001);

    // ---- write masks on ch1 (size/offset and translation) ----
    do_wr1(4'b1100, 32'h8000_0010, 32'hAABB_CCDD, 2'd1, 32'h0000_0012);
    do_wr1(4'b0001, 32'h0000_0023, 32'h0000_0011, 2'd0, 32'h0000_0020);
    do_wr1(4'b0010, 32'h0000_0023, 32'h0000_2200, 2'd0, 32'h0000_0021);
    do_wr1(4'b0100, 32'hC000_0000, 32'h0033_0000, 2'd0, 32'hC000_0002);
    do_wr1(4'b1000, 32'h0000_0020, 32'h4400_0000, 2'd0, 32'h0000_0023);
    do_wr1(4'b0011, 32'h0000_0022, 32'h0000_5566, 2'd1, 32'h0000_0020);
    do_wr1(4'b1111, 32'hA000_0013, 32'h1234_5678, 2'd2, 32'h0000_0010);
    do_wr1(4'b0110, 32'h4000_0041, 32'h0BAD_F00D, 2'd2, 32'h4000_0040);

    // ---- skewed completion ----
    cpu_en = 2'b11;
    cpu_size = {2'd0, 2'd2};
    cpu_addr = {32'h8000_2004, 32'h0000_1000};
    #1 chk("sk_c0_stall", stall, 1);
    step();
    bus_addr_ok = 2'b11;
    #1;
    chk("sk_c1_req", 32'(bus_req), 3);
    chk("sk_c1_addr1", bus_addr[63:32], 32'h0000_2004);
    chk("sk_c1_size1", bus_size[3:2], 0);
    step();
    bus_addr_ok = 2'b00; bus_data_ok = 2'b01; bus_rdata[31:0] = 32'h1111_2222;
    #1 chk("sk_c2_stall", stall, 1);
    step();
    bus_data_ok = 2'b00; bus_rdata[31:0] = 32'hFFFF_FFFF;
    for (int c = 3; c <= 6; c++) begin
      #1;
      chk("sk_hold_stall", stall, 1);
      chk("sk_hold_rdata0", cpu_rdata[31:0], 32'h1111_2222);
      step();
    end
    bus_data_ok = 2'b10; bus_rdata[63:32] = 32'h3333_4444;
    #1;
    chk("sk_c7_stall", stall, 1);
    chk("sk_c7_rdata0", cpu_rdata[31:0], 32'h1111_2222);
    step();
    bus_data_ok = 2'b00;
    #1;
    chk("sk_c8_stall", stall, 0);
    chk("sk_c8_rdata0", cpu_rdata[31:0], 32'h1111_2222);
    chk("sk_c8_rdata1", cpu_rdata[63:32], 32'h3333_4444);
    step();
    cpu_en = 2'b00;
    #1 chk("sk_c9_stall", stall, 0);

    // ---- backpressure: addr_ok withheld 5 cycles ----
    cpu_en[0] = 1'b1; cpu_size[1:0] = 2'd1; cpu_addr[31:0] = 32'h0000_0100;
    step();
    for (int k = 0; k < 5; k++) begin
      cpu_addr[31:0] = 32'h0000_0200 + 32'(k * 4);
      cpu_size[1:0]  = 2'(k);
      #1;
      chk("bp_req", bus_req[0], 1);
      chk("bp_addr", bus_addr[31:0], 32'h0000_0100);
      chk("bp_size", bus_size[1:0], 1);
      step();
    end
    bus_addr_ok[0] = 1'b1; bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'h0000_0BAD;
    #1 chk("bp_c6_req", bus_req[0], 1);
    step();
    bus_addr_ok[0] = 1'b0; bus_data_ok[0] = 1'b0;
    #1;
    chk("bp_both_stall", stall, 1);
    chk("bp_both_req", bus_req[0], 0);
    step();
    bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'h0000_BEEF;
    step();
    bus_data_ok[0] = 1'b0;
    #1;
    chk("bp_hold_stall", stall, 0);
    chk("bp_hold_rdata", cpu_rdata[31:0], 32'h0000_BEEF);
    step();
    cpu_en[0] = 1'b0;

    // ---- reset in DATA, then stale data_ok ----
    cpu_en[0] = 1'b1; cpu_size[1:0] = 2'd2; cpu_addr[31:0] = 32'h0000_0300;
    step();
    bus_addr_ok[0] = 1'b1;
    step();
    bus_addr_ok[0] = 1'b0;
    #2;
    rst = 1'b1; cpu_en = 2'b00;
    #1;
    chk("rst_mid_req", 32'(bus_req), 0);
    chk("rst_mid_addr", bus_addr[31:0], 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_rdata0", cpu_rdata[31:0], 0);
    chk("rst_mid_rdata1", cpu_rdata[63:32], 0);
    step();
    rst = 1'b0;
    bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'h0000_DEAD;
    step();
    bus_data_ok[0] = 1'b0;
    #1;
    chk("stale_rdata", cpu_rdata[31:0], 0);
    chk("stale_stall", stall, 0);
    chk("stale_req", bus_req[0], 0);
    cpu_en[0] = 1'b1; cpu_addr[31:0] = 32'h0000_0040;
    #1;
    chk("post_c0_stall", stall, 1);
    chk("post_c0_req", bus_req[0], 0);
    step();
    #1;
    chk("post_c1_req", bus_req[0], 1);
    chk("post_c1_addr", bus_addr[31:0], 32'h0000_0040);
    bus_addr_ok[0] = 1'b1;
    step();
    bus_addr_ok[0] = 1'b0; bus_data_ok[0] = 1'b1; bus_rdata[31:0] = 32'h5555_AAAA;
    step();
    bus_data_ok[0] = 1'b0;
    #1;
    chk("post_c3_stall", stall, 0);
    chk("post_c3_rdata", cpu_rdata[31:0], 32'h5555_AAAA);
    step();
    cpu_en[0] = 1'b0;

    // ---- pass-through instance ----
    m_en = 1'b1; m_size = 2'd2; m_addr = 32'h9000_0000;
    #1 chk("pt_c0_stall", m_stall, 1);
    step();
    #1;
    chk("pt_req", m_bus_req, 1);
    chk("pt_addr", m_bus_addr, 32'h9000_0000);
    m_addr_ok = 1'b1;
    step();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_bus_rdata = 32'h1234_5678;
    step();
    m_data_ok = 1'b0;
    #1;
    chk("pt_stall", m_stall, 0);
    chk("pt_rdata", m_rdata, 32'h1234_5678);
    step();
    m_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
